// File: rtl/float_align_shifter.sv
// rtl/float_align_shifter.sv - significand alignment stage for the float adder pipeline
//
// Picks the larger/smaller of two single-precision operands from the swap bit
// of the exponent-difference word, then right-shifts the smaller significand
// by the (clamped) exponent difference while keeping guard/round/sticky bits.
// Only one operation is in flight at a time.
//
// Ports:
//   clk, res            - clock (rising edge), synchronous active-high reset
//   a, b                - IEEE-754 operands {sign, exp, frac}
//   diff                - {swap, |exp_a-exp_b|}; swap=1 means B is larger
//   in_valid/in_ready   - input handshake (ready only while idle)
//   out_valid/out_ready - output handshake (outputs held while waiting)
//   swapped             - latched swap bit
//   sign_big/sign_small - signs of larger/smaller operand
//   exp_out             - exponent of the larger operand
//   mant_big            - {hidden, frac} of the larger operand
//   mant_small          - aligned {hidden, frac, G, R, S} of the smaller operand
//
// Build option: FAST_ALIGN_EN selects a single-cycle barrel shifter in place
// of the iterative one-bit-per-cycle shifter.

module float_align_shifter #(
  parameter int EXP_W     = 8,
  parameter int MANT_W    = 23,
  parameter int MAX_SHIFT = 27
) (
  input  logic                      clk,
  input  logic                      res,
  input  logic [EXP_W+MANT_W:0]     a,
  input  logic [EXP_W+MANT_W:0]     b,
  input  logic [EXP_W:0]            diff,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      swapped,
  output logic                      sign_big,
  output logic                      sign_small,
  output logic [EXP_W-1:0]          exp_out,
  output logic [MANT_W:0]           mant_big,
  output logic [MANT_W+3:0]         mant_small
);

  localparam int TOT_W = 1 + EXP_W + MANT_W;
  localparam int SIG_W = MANT_W + 1;
  localparam int AL_W  = MANT_W + 4;
  localparam int CNT_W = $clog2(MAX_SHIFT + 1);
  localparam logic [EXP_W-1:0] MAX_SHIFT_E = EXP_W'(MAX_SHIFT);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              swapped_q, swapped_d;
  logic              sign_big_q, sign_big_d;
  logic              sign_small_q, sign_small_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [SIG_W-1:0]  mant_big_q, mant_big_d;
  logic [AL_W-1:0]   mant_small_q, mant_small_d;

  // Operand selection and initial alignment value, only meaningful in IDLE.
  logic [TOT_W-1:0]  big_op, small_op;
  logic              hid_big, hid_small;
  logic [AL_W-1:0]   al_init;
  logic [CNT_W-1:0]  shamt;

`ifdef FAST_ALIGN_EN
  logic [AL_W-1:0]   fast_mask;
  logic [AL_W-1:0]   fast_shifted;
  logic              fast_sticky;
`endif

  always_comb begin
    big_op    = diff[EXP_W] ? b : a;
    small_op  = diff[EXP_W] ? a : b;
    hid_big   = |big_op[TOT_W-2:MANT_W];
    hid_small = |small_op[TOT_W-2:MANT_W];
    al_init   = {hid_small, small_op[MANT_W-1:0], 3'b000};
    // Differences beyond MAX_SHIFT would only feed the sticky bit anyway.
    shamt     = (diff[EXP_W-1:0] >= MAX_SHIFT_E) ? CNT_W'(MAX_SHIFT)
                                                 : CNT_W'(diff[EXP_W-1:0]);
  end

`ifdef FAST_ALIGN_EN
  // At the clamp the mask wraps to all ones, folding every bit into sticky.
  always_comb begin
    fast_mask    = (AL_W'(1) << shamt) - AL_W'(1);
    fast_shifted = al_init >> shamt;
    fast_sticky  = |(al_init & fast_mask);
  end
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    swapped_d    = swapped_q;
    sign_big_d   = sign_big_q;
    sign_small_d = sign_small_q;
    exp_d        = exp_q;
    mant_big_d   = mant_big_q;
    mant_small_d = mant_small_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          swapped_d    = diff[EXP_W];
          sign_big_d   = big_op[TOT_W-1];
          sign_small_d = small_op[TOT_W-1];
          exp_d        = big_op[TOT_W-2:MANT_W];
          mant_big_d   = {hid_big, big_op[MANT_W-1:0]};
          in_ready_d   = 1'b0;
          cnt_d        = shamt;
`ifdef FAST_ALIGN_EN
          mant_small_d = {fast_shifted[AL_W-1:1], fast_shifted[0] | fast_sticky};
          state_d      = DONE;
          out_valid_d  = 1'b1;
`else
          mant_small_d = al_init;
          if (shamt == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
          end else begin
            state_d     = SHIFT;
          end
`endif
        end
      end

      SHIFT: begin
        // Bit 0 is the sticky bit: it ORs in everything shifted past it.
        mant_small_d = {1'b0, mant_small_q[AL_W-1:2], mant_small_q[1] | mant_small_q[0]};
        cnt_d        = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      swapped_q    <= 1'b0;
      sign_big_q   <= 1'b0;
      sign_small_q <= 1'b0;
      exp_q        <= '0;
      mant_big_q   <= '0;
      mant_small_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      swapped_q    <= swapped_d;
      sign_big_q   <= sign_big_d;
      sign_small_q <= sign_small_d;
      exp_q        <= exp_d;
      mant_big_q   <= mant_big_d;
      mant_small_q <= mant_small_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign swapped    = swapped_q;
  assign sign_big   = sign_big_q;
  assign sign_small = sign_small_q;
  assign exp_out    = exp_q;
  assign mant_big   = mant_big_q;
  assign mant_small = mant_small_q;

endmodule

// File: tb/tb_float_align_shifter.sv
// tb/tb_float_align_shifter.sv - directed self-checking bench for float_align_shifter

module tb_float_align_shifter;

  logic        clk = 1'b0;
  logic        res;
  logic [31:0] a, b;
  logic [8:0]  diff;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        swapped, sign_big, sign_small;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  float_align_shifter dut (
    .clk(clk), .res(res), .a(a), .b(b), .diff(diff),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .swapped(swapped), .sign_big(sign_big), .sign_small(sign_small),
    .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small)
  );

  function automatic int exp_lat(input int n);
`ifdef FAST_ALIGN_EN
    return 1;
`else
    return n + 1;
`endif
  endfunction

  // Present one operation for a single edge; inputs change 1ns after edges.
  task automatic accept(input logic [31:0] ia, input logic [31:0] ib, input logic [8:0] id);
    int guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    a = ia; b = ib; diff = id; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called right after the accepting edge; returns cycles until out_valid (999 on timeout).
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = 999;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if ({swapped, sign_big, sign_small, exp_out, mant_big, mant_small} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h/%h/%h exp=0", exp_out, mant_big, mant_small);
    end
    res = 1'b0;
  endtask

  task automatic test_basic();
    int lat;
    accept(32'h40400000, 32'h3F800000, 9'h001);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(1)) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", lat, exp_lat(1)); end
    checks++; if (swapped !== 1'b0) begin failures++; $display("FAIL basic_swapped got=%b exp=0", swapped); end
    checks++; if (exp_out !== 8'h80) begin failures++; $display("FAIL basic_exp got=%h exp=80", exp_out); end
    checks++; if (mant_big !== 24'hC00000) begin failures++; $display("FAIL basic_mant_big got=%h exp=c00000", mant_big); end
    checks++; if (mant_small !== 27'h2000000) begin failures++; $display("FAIL basic_mant_small got=%h exp=2000000", mant_small); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL basic_in_ready_busy got=%b exp=0", in_ready); end
    drain();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL basic_return_idle got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_swap();
    int lat;
    accept(32'h3F800000, 32'h40400000, 9'h101);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(1)) begin failures++; $display("FAIL swap_latency got=%0d exp=%0d", lat, exp_lat(1)); end
    checks++; if ({swapped, sign_big} !== 2'b10) begin failures++; $display("FAIL swap_flags got=%b exp=10", {swapped, sign_big}); end
    checks++; if (exp_out !== 8'h80) begin failures++; $display("FAIL swap_exp got=%h exp=80", exp_out); end
    checks++; if (mant_big !== 24'hC00000) begin failures++; $display("FAIL swap_mant_big got=%h exp=c00000", mant_big); end
    checks++; if (mant_small !== 27'h2000000) begin failures++; $display("FAIL swap_mant_small got=%h exp=2000000", mant_small); end
    drain();
  endtask

  task automatic test_zero_shift();
    int lat;
    accept(32'h3F800000, 32'h3F800000, 9'h000);
    wait_valid(lat);
    checks++; if (lat !== 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
    checks++; if (mant_small !== 27'h4000000) begin failures++; $display("FAIL zero_mant_small got=%h exp=4000000", mant_small); end
    checks++; if (exp_out !== 8'h7F) begin failures++; $display("FAIL zero_exp got=%h exp=7f", exp_out); end
    drain();
  endtask

  task automatic test_sticky();
    int lat;
    // 0x800001<<3 = 0x4000008; >>5 = 0x200000, dropped bit 3 sets sticky.
    accept(32'h41000000, 32'hBF800001, 9'h005);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(5)) begin failures++; $display("FAIL sticky_latency got=%0d exp=%0d", lat, exp_lat(5)); end
    checks++; if (mant_small !== 27'h0200001) begin failures++; $display("FAIL sticky_mant_small got=%h exp=0200001", mant_small); end
    checks++; if ({sign_big, sign_small} !== 2'b01) begin failures++; $display("FAIL sticky_signs got=%b exp=01", {sign_big, sign_small}); end
    checks++; if (exp_out !== 8'h82) begin failures++; $display("FAIL sticky_exp got=%h exp=82", exp_out); end
    drain();
  endtask

  task automatic test_clamp();
    int lat;
    accept(32'h4B800001, 32'h3F800000, 9'h028);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(27)) begin failures++; $display("FAIL clamp_latency got=%0d exp=%0d", lat, exp_lat(27)); end
    checks++; if (mant_small !== 27'h0000001) begin failures++; $display("FAIL clamp_mant_small got=%h exp=0000001", mant_small); end
    checks++; if (mant_big !== 24'h800001) begin failures++; $display("FAIL clamp_mant_big got=%h exp=800001", mant_big); end
    checks++; if (exp_out !== 8'h97) begin failures++; $display("FAIL clamp_exp got=%h exp=97", exp_out); end
    drain();
    // Zero small operand: hidden bit 0, nothing to make sticky.
    accept(32'h4B800001, 32'h00000000, 9'h028);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(27)) begin failures++; $display("FAIL clamp_zero_latency got=%0d exp=%0d", lat, exp_lat(27)); end
    checks++; if (mant_small !== 27'h0) begin failures++; $display("FAIL clamp_zero_mant_small got=%h exp=0", mant_small); end
    drain();
  endtask

  task automatic test_backpressure();
    int lat;
    accept(32'h40400000, 32'h3F800000, 9'h001);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(1)) begin failures++; $display("FAIL bp_latency got=%0d exp=%0d", lat, exp_lat(1)); end
    // A competing request while busy must be ignored.
    a = 32'h3F800000; b = 32'h40400000; diff = 9'h101; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, swapped, exp_out, mant_big, mant_small} !== {1'b1, 1'b0, 1'b0, 8'h80, 24'hC00000, 27'h2000000}) begin
        failures++;
        $display("FAIL bp_hold cycle=%0d got=%b%b %h %h %h exp=10 80 c00000 2000000", i, out_valid, in_ready, exp_out, mant_big, mant_small);
      end
    end
    in_valid = 1'b0;
    drain();
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL bp_return_idle got=%b exp=10", {in_ready, out_valid}); end
  endtask

  task automatic test_reset_mid_shift();
    int lat;
    accept(32'h4B800001, 32'h3F800000, 9'h028);
    repeat (9) @(posedge clk);
    #1;
    res = 1'b1;
    @(posedge clk); #1;
    res = 1'b0;
    checks++; if ({in_ready, out_valid} !== 2'b10) begin failures++; $display("FAIL rst_mid_handshake got=%b exp=10", {in_ready, out_valid}); end
    checks++; if ({swapped, sign_big, sign_small, exp_out, mant_big, mant_small} !== '0) begin
      failures++; $display("FAIL rst_mid_outputs got=%h/%h/%h exp=0", exp_out, mant_big, mant_small);
    end
    accept(32'h40400000, 32'h3F800000, 9'h001);
    wait_valid(lat);
    checks++; if (lat !== exp_lat(1)) begin failures++; $display("FAIL rst_mid_fresh_latency got=%0d exp=%0d", lat, exp_lat(1)); end
    checks++; if ({exp_out, mant_big, mant_small} !== {8'h80, 24'hC00000, 27'h2000000}) begin
      failures++; $display("FAIL rst_mid_fresh_result got=%h/%h/%h exp=80/c00000/2000000", exp_out, mant_big, mant_small);
    end
    drain();
  endtask

  initial begin
    res = 1'b1; a = '0; b = '0; diff = '0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_swap();
    test_zero_shift();
    test_sticky();
    test_clamp();
    test_backpressure();
    test_reset_mid_shift();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/float_align_shifter.md
Name: float_align_shifter

Overview:
- Downstream consumer of the exponent-difference stage in the float adder pipeline.
- Takes two IEEE-754 single-precision operands plus the 9-bit exponent-difference word {swap, |ea-eb|}.
- Selects the larger and smaller operand and right-shifts the smaller significand one bit per cycle, with guard/round/sticky.
- Presents the aligned significand pair and common exponent to the mantissa adder through a valid/ready handshake.

Parameters:
EXP_W, 8, exponent field width
MANT_W, 23, stored fraction width (significand = MANT_W+1 with hidden bit)
MAX_SHIFT, 27, shift count clamp (= MANT_W+1+3); larger differences are clamped to this value

Ports:
clk  in  1  clock, rising edge
res  in  1  synchronous reset, active-high
a  in  32  operand A (sign, exp[30:23], frac[22:0])
b  in  32  operand B
diff  in  9  [8]=1 when exp_b>exp_a (swap); [7:0]=|exp_a-exp_b|
in_valid  in  1  a/b/diff valid
in_ready  out  1  block can accept (high only in IDLE)
out_valid  out  1  aligned result valid
out_ready  in  1  downstream accepts result
swapped  out  1  latched diff[8]; 1 = B is the larger operand
sign_big  out  1  sign of the larger operand
sign_small  out  1  sign of the smaller operand
exp_out  out  8  exponent of the larger operand
mant_big  out  24  {hidden, frac} of the larger operand
mant_small  out  27  aligned {hidden, frac, G, R, S} of the smaller operand

Behaviour:
- Reset (res=1 at posedge), from any state including mid-shift:
  - state returns to IDLE.
  - All outputs and internal registers are cleared to 0, except in_ready=1 in the cycle after reset.
- Hidden bit is 1 if the operand's exponent is nonzero, otherwise 0 (denormal/zero).
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, capture operands: big = diff[8] ? b : a, small = the other operand.
  - mant_small loads {hidden, frac, 3'b000}.
  - cnt = min(diff[7:0], MAX_SHIFT).
  - Next state is DONE if cnt=0, otherwise SHIFT.
- SHIFT:
  - Each cycle, mant_small <= {1'b0, mant_small[26:1]} with new bit0 = mant_small[1] | mant_small[0] (sticky accumulates); cnt decrements.
  - Transition to DONE in the cycle cnt goes 1 -> 0.
- DONE:
  - out_valid=1; all outputs held stable.
  - On out_ready=1, go to IDLE; in_ready rises the next cycle.
- Latency: out_valid asserts n+1 cycles after the accepting edge, where n = clamped shift count.
- Throughput: one operation in flight at a time; no input is accepted in SHIFT or DONE.
- in_valid while not in IDLE is ignored; the upstream stage must hold its data until it sees in_ready.
- diff is trusted as given; it is not recomputed from a/b.
- Clamp: any diff[7:0] >= 27 yields mant_small = 27'h0000001 if the small significand is nonzero, and 0 otherwise.
- swapped=1 with diff[7:0]=0 is legal: B is treated as the larger operand, with 0 shifts.

Optional Feature:
FAST_ALIGN_EN
- Defined: a single-cycle barrel shifter with OR-reduced sticky computes the aligned value at accept time.
  - The SHIFT state is never entered; out_valid is always 1 cycle after accept.
  - Results are bit-identical to the iterative path.
- Undefined: the iterative 1-bit/cycle shifter described above is used.

Test Plan:
- a=32'h40400000, b=32'h3F800000, diff=9'h001 -> one SHIFT cycle; out_valid 2 cycles after accept; swapped=0, exp_out=8'h80, mant_big=24'hC00000, mant_small=27'h2000000.
- a=32'h3F800000, b=32'h40400000, diff=9'h101 -> swapped=1, sign_big=0, exp_out=8'h80, mant_big=24'hC00000, mant_small=27'h2000000.
- a=b=32'h3F800000, diff=9'h000 -> out_valid 1 cycle after accept; mant_small=27'h4000000, exp_out=8'h7F.
- a=32'h4B800001, b=32'h3F800000, diff=9'h028 -> clamped to 27 shifts; out_valid 28 cycles after accept; mant_small=27'h0000001.
- Case 1 with out_ready=0 for 5 cycles -> out_valid and outputs held stable, in_ready=0 throughout; IDLE one cycle after out_ready=1.
- Case 4 with res=1 asserted 10 cycles into SHIFT -> next cycle all outputs 0, in_ready=1; a fresh case-1 transaction then completes correctly.
